mult16_seq_ctrl: RTL and testbench

- Sequential 16x16 unsigned shift-add multiplier.
- Time-multiplexes one existing 16-bit ripple adder (fulladder16, Cin tied 0) over 16 iterations to form a 32-bit product.
- Sits beside the ALU as a multi-cycle functional unit with a start/done handshake.

---
 rtl/mult16_pkg.sv | 12 +
 rtl/fulladder16.sv | 23 ++
 rtl/mult16_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_mult16_seq_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mult16_pkg.sv
// mult16_pkg: shared constants and types for the sequential 16x16 multiplier.
//   WIDTH     - operand width, fixed to the datapath adder width
//   CNT_W     - iteration counter width (holds 0..16)
//   LAST_ITER - counter value on the final shift-add iteration
//   state_t   - controller states IDLE / RUN / DONE
package mult16_pkg;
  localparam int WIDTH = 16;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(15);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/fulladder16.sv
// fulladder16: 16-bit ripple-carry adder.
//   A, B - addends
//   Cin  - carry in
//   S    - sum
//   Cout - carry out of bit 15
module fulladder16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout
);
  logic [16:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < 16; i++) begin : g_bit
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[16];
endmodule

// File: rtl/mult16_seq_ctrl.sv
// mult16_seq_ctrl: sequential 16x16 unsigned shift-add multiplier.
// One fulladder16 is reused for 16 iterations; result lands in P after
// 17 cycles with a one-cycle done pulse.
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   start - request a multiply (ignored while busy)
//   A, B  - multiplicand / multiplier, latched on accepted start
//   busy  - high while iterating
//   done  - one-cycle pulse, P holds the new product
//   P     - last completed 32-bit product
//   ovf   - (only with MULT16_OVF_EN) product needs more than 16 bits
// Optional feature macro: MULT16_OVF_EN
module mult16_seq_ctrl
  import mult16_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
`ifdef MULT16_OVF_EN
  ,
  output logic               ovf
`endif
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
`ifdef MULT16_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic [WIDTH-1:0] add_op, sum;
  logic             cout;
  logic             last;

  assign last   = (cnt_q == LAST_ITER);
  assign add_op = lo_q[0] ? mcand_q : '0;

  fulladder16 u_add (
    .A    (hi_q),
    .B    (add_op),
    .Cin  (1'b0),
    .S    (sum),
    .Cout (cout)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Datapath next-state
  always_comb begin
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    if (state_q == RUN) begin
      // {c,s,lo} >> 1: carry enters hi MSB, sum LSB enters lo MSB
      hi_d  = {cout, sum[WIDTH-1:1]};
      lo_d  = {sum[0], lo_q[WIDTH-1:1]};
      cnt_d = cnt_q + 1'b1;
      if (last) p_d = {hi_d, lo_d};
    end else if (start) begin
      // IDLE and DONE both accept start, giving back-to-back operation
      mcand_d = A;
      hi_d    = '0;
      lo_d    = B;
      cnt_d   = '0;
    end
  end

`ifdef MULT16_OVF_EN
  assign ovf_d = (state_q == RUN && last) ? |p_d[2*WIDTH-1:WIDTH] : ovf_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
`ifdef MULT16_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
`ifdef MULT16_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign P = p_q;
`ifdef MULT16_OVF_EN
  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_mult16_seq_ctrl.sv
module tb_mult16_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        busy, done;
  logic [31:0] P;
`ifdef MULT16_OVF_EN
  logic        ovf;
`endif

  int total = 0;
  int passed = 0;

  mult16_seq_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
`ifdef MULT16_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until done; returns ticks taken, -1 if the bound expires.
  task automatic wait_done(output int cyc);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 40);
    cyc = done ? n : -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if ({busy, done} !== 2'b00) $display("FAIL reset_flags busy/done=%b want 00", {busy, done}); else passed++;
    total++; if (P !== 32'h0) $display("FAIL reset_P got %h want 00000000", P); else passed++;
`ifdef MULT16_OVF_EN
    total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else passed++;
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int bad_busy, bad_p;
    bad_busy = 0; bad_p = 0;
    A = 16'd3; B = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    A = 16'hDEAD; B = 16'hBEEF;  // don't-care after latching
    total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL basic_busy_rise busy=%b done=%b want 1 0", busy, done); else passed++;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
      if (P !== 32'h0) bad_p++;
    end
    total++; if (bad_busy != 0) $display("FAIL basic_busy_window bad cycles=%0d want 0", bad_busy); else passed++;
    total++; if (bad_p != 0) $display("FAIL basic_P_hidden bad cycles=%0d want 0", bad_p); else passed++;
    tick();
    total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL basic_done_latency done=%b busy=%b want 1 0", done, busy); else passed++;
    total++; if (P !== 32'h0000000F) $display("FAIL basic_P got %h want 0000000f", P); else passed++;
`ifdef MULT16_OVF_EN
    total++; if (ovf !== 1'b0) $display("FAIL basic_ovf got %b want 0", ovf); else passed++;
`endif
    tick();
    total++; if (done !== 1'b0 || P !== 32'h0000000F) $display("FAIL basic_after done=%b P=%h want 0 0000000f", done, P); else passed++;
  endtask

  task automatic test_max();
    int cyc;
    A = 16'hFFFF; B = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc);
    total++; if (cyc != 16) $display("FAIL max_latency got %0d want 16", cyc); else passed++;
    total++; if (P !== 32'hFFFE0001) $display("FAIL max_P got %h want fffe0001", P); else passed++;
`ifdef MULT16_OVF_EN
    total++; if (ovf !== 1'b1) $display("FAIL max_ovf got %b want 1", ovf); else passed++;
`endif
    tick();
  endtask

  task automatic test_zero_ignored();
    int cyc;
    A = 16'h1234; B = 16'h0000; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc);
    total++; if (cyc != 16 || P !== 32'h0) $display("FAIL zero_P cyc=%0d P=%h want 16 00000000", cyc, P); else passed++;
    tick();
    A = 16'h0011; B = 16'h0003; start = 1'b1;
    tick();
    A = 16'd7; B = 16'd9;  // start held during RUN: must be ignored
    for (int i = 0; i < 6; i++) tick();
    start = 1'b0;
    wait_done(cyc);
    total++; if (cyc != 10) $display("FAIL ignored_latency got %0d want 10", cyc); else passed++;
    total++; if (P !== 32'h00000033) $display("FAIL ignored_P got %h want 00000033", P); else passed++;
    tick();
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL ignored_idle busy=%b done=%b want 0 0", busy, done); else passed++;
  endtask

  task automatic test_reset_mid();
    int cyc, dpulse;
    dpulse = 0;
    A = 16'd5; B = 16'd6; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    #1;  // asynchronous: no clock edge needed
    total++; if ({busy, done} !== 2'b00 || P !== 32'h0) $display("FAIL midrst_async busy/done=%b P=%h want 00 00000000", {busy, done}, P); else passed++;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) dpulse++;
    end
    total++; if (dpulse != 0) $display("FAIL midrst_no_done bad cycles=%0d want 0", dpulse); else passed++;
    A = 16'd2; B = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc);
    total++; if (cyc != 16 || P !== 32'h4) $display("FAIL midrst_next cyc=%0d P=%h want 16 00000004", cyc, P); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc;
    A = 16'h0100; B = 16'h0100; start = 1'b1;
    tick();
    wait_done(cyc);
    total++; if (cyc != 16 || P !== 32'h00010000) $display("FAIL b2b_first cyc=%0d P=%h want 16 00010000", cyc, P); else passed++;
`ifdef MULT16_OVF_EN
    total++; if (ovf !== 1'b1) $display("FAIL b2b_ovf got %b want 1", ovf); else passed++;
`endif
    A = 16'h0003; B = 16'h0004;  // latched by the DONE-state start
    tick();
    start = 1'b0;
    total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_no_idle busy=%b done=%b want 1 0", busy, done); else passed++;
    wait_done(cyc);
    total++; if (cyc != 16 || P !== 32'h0000000C) $display("FAIL b2b_second cyc=%0d P=%h want 16 0000000c", cyc, P); else passed++;
`ifdef MULT16_OVF_EN
    total++; if (ovf !== 1'b0) $display("FAIL b2b_ovf_clear got %b want 0", ovf); else passed++;
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
